pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the write enables and flush inputs of the PC, IF/ID, ID/EX and EX/MEM pipe registers:
  - from load-use hazards detected in ID,
  - from branch/jump resolution in MEM,
  - from the data-memory ready handshake.
- Holds a small FSM with a wait-timeout for slow memory, and saturating stall/flush event counters for performance debug.

Parameters:
- TIMEOUT, 16: max MEM_WAIT cycles before entering ERR; legal range 2..255.
- CNT_W, 16: width of the stall and flush event counters.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- id_rs_i  in  5  rs field of the instruction in ID
- id_rt_i  in  5  rt field of the instruction in ID
- id_uses_rt_i  in  1  the ID instruction reads rt (R-type, beq, sw)
- ex_memread_i  in  1  ID/EX MemRead (a load is in EX)
- ex_rt_i  in  5  ID/EX destination rt of that load
- mem_branch_i  in  1  EX/MEM Branch
- mem_zero_i  in  1  EX/MEM Zero
- mem_jump_i  in  1  EX/MEM Jump
- dmem_req_i  in  1  MEM stage MemRead|MemWrite
- dmem_ready_i  in  1  data memory done this cycle
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID write enable
- pc_src_o  out  1  select branch/jump target (EX/MEM add_branch)
- ifid_flush_o  out  1  zero IF/ID
- idex_flush_o  out  1  zero ID/EX control (insert bubble)
- ex_flush_o  out  1  zero EX/MEM
- pipe_hold_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
- err_o  out  1  sticky memory-timeout error
- state_o  out  2  current FSM state
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0
- flush_cnt_o  out  CNT_W  redirects taken

Behaviour:
- FSM states: RUN=0, MEM_WAIT=1, ERR=2; encoding 3 is unused and must recover to RUN.
- Registered: state, wait counter (8 bit), err_o, stall_cnt_o, flush_cnt_o.
- All other outputs are combinational (Mealy) from state and inputs; they act in the same cycle.
- Reset (rst_i=0, async):
  - state=RUN, wait counter=0, err_o=0, both counters=0.
  - While reset is asserted: pc_write_o=0, ifid_write_o=0, pc_src_o=0, pipe_hold_o=0, all three flush outputs=1.
- Definitions:
  - redirect = mem_jump_i | (mem_branch_i & mem_zero_i)
  - lu_hazard = ex_memread_i & (ex_rt_i!=0) & ((ex_rt_i==id_rs_i) | (id_uses_rt_i & ex_rt_i==id_rt_i))
- RUN, evaluated by priority:
  1. dmem_req_i & !dmem_ready_i:
     - pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, no flush.
     - Next state MEM_WAIT, wait counter=1.
  2. redirect:
     - pc_src_o=1, pc_write_o=1, ifid_write_o=1.
     - ifid_flush_o=1, idex_flush_o=1, ex_flush_o=1 (squash the 3 younger instructions).
     - flush_cnt_o+1. A concurrent lu_hazard is ignored.
  3. lu_hazard:
     - pc_write_o=0, ifid_write_o=0, idex_flush_o=1 (one bubble).
     - Resolves by itself next cycle.
  4. Otherwise: pc_write_o=1, ifid_write_o=1, all flushes=0, pipe_hold_o=0.
- Zero-wait memory (dmem_req_i & dmem_ready_i in RUN) causes no stall.
- MEM_WAIT:
  - dmem_ready_i=1: outputs as in RUN cases 2-4 (pipeline advances this cycle); next state RUN; wait counter=0.
  - Otherwise: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1; wait counter+1.
  - Wait counter==TIMEOUT-1 with ready still 0: next state ERR, err_o=1.
  - redirect is not evaluated while held.
- ERR:
  - Same freeze outputs as MEM_WAIT.
  - err_o stays 1; only reset exits.
- stall_cnt_o increments every cycle with pc_write_o=0 after reset; both counters saturate at all-ones.
- Reset mid-MEM_WAIT or in ERR returns to RUN immediately (async).

Decomposition:
- pipe_ctrl_pkg: state encodings (ST_RUN, ST_MEM_WAIT, ST_ERR), REG_ZERO=5'd0, default TIMEOUT constant.
- One sub-module, sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice for stall_cnt_o and flush_cnt_o.
- Hazard and next-state logic stay in the top module.

Test Plan:
- Load-use: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 -> one cycle of pc_write_o=0, ifid_write_o=0, idex_flush_o=1; stall_cnt_o=1; next cycle with ex_memread_i=0 -> normal flow.
- rt gating: ex_rt_i=0, id_rs_i=0 -> no stall; ex_rt_i=9, id_rt_i=9, id_uses_rt_i=0 -> no stall; id_uses_rt_i=1 -> stall.
- Branch taken plus concurrent load-use: mem_branch_i=1, mem_zero_i=1, lu_hazard=1 -> pc_src_o=1, all three flushes=1, pc_write_o=1, flush_cnt_o=1, no stall.
- Memory wait: dmem_req_i=1 with ready low for 3 cycles, then high -> state_o 1,1,1, then RUN; pipe_hold_o=1 for 3 cycles; stall_cnt_o=3.
- Timeout with TIMEOUT=4: ready never rises -> state_o=2, err_o=1 after the 4th held cycle; remains frozen; rst_i pulse low -> state_o=0, err_o=0, counters 0.
- Saturation with CNT_W=4: 20 load-use stalls -> stall_cnt_o=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared encodings and constants for the pipeline hazard controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         TIMEOUT_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Event counter that sticks at all-ones instead of wrapping
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage pipeline with memory timeout
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             mem_branch_i,
    input  logic             mem_zero_i,
    input  logic             mem_jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             pc_src_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             ex_flush_o,
    output logic             pipe_hold_o,
    output logic             err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e     state_q;
    logic [7:0] wait_q;
    logic       err_q;

    logic w_redirect;
    logic w_lu_hazard;
    logic w_freeze;
    logic w_flush_event;

    assign w_redirect  = mem_jump_i | (mem_branch_i & mem_zero_i);
    assign w_lu_hazard = ex_memread_i & (ex_rt_i != REG_ZERO) &
                         ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

    // Freeze covers a fresh memory miss, an ongoing wait, and the error state;
    // the unused encoding behaves like RUN.
    always_comb begin
        w_freeze = 1'b0;
        case (state_q)
            ST_MEM_WAIT: w_freeze = ~dmem_ready_i;
            ST_ERR:      w_freeze = 1'b1;
            default:     w_freeze = dmem_req_i & ~dmem_ready_i;
        endcase
    end

    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        pc_src_o     = 1'b0;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        ex_flush_o   = 1'b0;
        pipe_hold_o  = 1'b0;
        if (!rst_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            ex_flush_o   = 1'b1;
        end else if (w_freeze) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
        end else if (w_redirect) begin
            pc_src_o     = 1'b1;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            ex_flush_o   = 1'b1;
        end else if (w_lu_hazard) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_MEM_WAIT: begin
                    if (dmem_ready_i) begin
                        state_q <= ST_RUN;
                        wait_q  <= 8'd0;
                    end else if (wait_q == 8'(TIMEOUT - 1)) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q  <= wait_q + 8'd1;
                    end
                end
                ST_ERR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    if (dmem_req_i && !dmem_ready_i) begin
                        state_q <= ST_MEM_WAIT;
                        wait_q  <= 8'd1;
                    end else begin
                        state_q <= ST_RUN;
                        wait_q  <= 8'd0;
                    end
                end
            endcase
        end
    end

    assign err_o         = err_q;
    assign state_o       = state_q;
    assign w_flush_event = ~w_freeze & w_redirect;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (~pc_write_o),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_flush_event),
        .cnt_o (flush_cnt_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed scoreboard bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    // {pc_write, ifid_write, pc_src, ifid_flush, idex_flush, ex_flush, pipe_hold}
    localparam logic [6:0] C_NORM = 7'b1100000;
    localparam logic [6:0] C_LU   = 7'b0000100;
    localparam logic [6:0] C_RED  = 7'b1111110;
    localparam logic [6:0] C_HOLD = 7'b0000001;
    localparam logic [6:0] C_RST  = 7'b0001110;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [4:0]       id_rs_i, id_rt_i, ex_rt_i;
    logic             id_uses_rt_i, ex_memread_i;
    logic             mem_branch_i, mem_zero_i, mem_jump_i;
    logic             dmem_req_i, dmem_ready_i;
    logic             pc_write_o, ifid_write_o, pc_src_o;
    logic             ifid_flush_o, idex_flush_o, ex_flush_o, pipe_hold_o;
    logic             err_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
    logic [6:0]       ctl_obs;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_uses_rt_i (id_uses_rt_i),
        .ex_memread_i (ex_memread_i),
        .ex_rt_i      (ex_rt_i),
        .mem_branch_i (mem_branch_i),
        .mem_zero_i   (mem_zero_i),
        .mem_jump_i   (mem_jump_i),
        .dmem_req_i   (dmem_req_i),
        .dmem_ready_i (dmem_ready_i),
        .pc_write_o   (pc_write_o),
        .ifid_write_o (ifid_write_o),
        .pc_src_o     (pc_src_o),
        .ifid_flush_o (ifid_flush_o),
        .idex_flush_o (idex_flush_o),
        .ex_flush_o   (ex_flush_o),
        .pipe_hold_o  (pipe_hold_o),
        .err_o        (err_o),
        .state_o      (state_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
    );

    assign ctl_obs = {pc_write_o, ifid_write_o, pc_src_o, ifid_flush_o,
                      idex_flush_o, ex_flush_o, pipe_hold_o};

    typedef struct {
        string            tag;
        logic [6:0]       ctl;
        logic [1:0]       st;
        logic             err;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic setin(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mr, input logic [4:0] ert, input logic br,
                         input logic z, input logic j, input logic req, input logic rdy);
        id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = uses;
        ex_memread_i = mr; ex_rt_i = ert;
        mem_branch_i = br; mem_zero_i = z; mem_jump_i = j;
        dmem_req_i = req; dmem_ready_i = rdy;
    endtask

    task automatic idle();
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Push the expectation for the current inputs, compare mid-cycle, then advance.
    task automatic step(input string tag, input logic [6:0] ctl, input logic [1:0] st,
                        input logic err, input int stall, input int flush);
        exp_t e;
        exp_t got;
        e.tag = tag; e.ctl = ctl; e.st = st; e.err = err;
        e.stall = CNT_W'(stall); e.flush = CNT_W'(flush);
        sb.push_back(e);
        @(negedge clk_i);
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            got = sb.pop_front();
            check({got.tag, ".ctl"},   16'(ctl_obs),     16'(got.ctl));
            check({got.tag, ".state"}, 16'(state_o),     16'(got.st));
            check({got.tag, ".err"},   16'(err_o),       16'(got.err));
            check({got.tag, ".stall"}, 16'(stall_cnt_o), 16'(got.stall));
            check({got.tag, ".flush"}, 16'(flush_cnt_o), 16'(got.flush));
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        idle();
        rst_i = 1'b0;
        step("reset", C_RST, 2'd0, 1'b0, 0, 0);
        rst_i = 1'b1;

        idle();                                                   step("idle0",      C_NORM, 2'd0, 1'b0, 0, 0);
        setin(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                                                                  step("lu_rs",      C_LU,   2'd0, 1'b0, 0, 0);
        idle();                                                   step("lu_done",    C_NORM, 2'd0, 1'b0, 1, 0);
        setin(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                                                                  step("lu_r0",      C_NORM, 2'd0, 1'b0, 1, 0);
        setin(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                                                                  step("lu_rt_off",  C_NORM, 2'd0, 1'b0, 1, 0);
        setin(5'd0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                                                                  step("lu_rt_on",   C_LU,   2'd0, 1'b0, 1, 0);
        setin(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                                                                  step("br_lu",      C_RED,  2'd0, 1'b0, 2, 0);
        idle();                                                   step("after_br",   C_NORM, 2'd0, 1'b0, 2, 1);
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                                                                  step("jump",       C_RED,  2'd0, 1'b0, 2, 1);
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                                                                  step("br_nt",      C_NORM, 2'd0, 1'b0, 2, 2);
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                                                                  step("mem_0wait",  C_NORM, 2'd0, 1'b0, 2, 2);

        // Three low-ready cycles, ready on the fourth
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mw1", C_HOLD, 2'd0, 1'b0, 2, 2);
        step("mw2", C_HOLD, 2'd1, 1'b0, 3, 2);
        step("mw3", C_HOLD, 2'd1, 1'b0, 4, 2);
        dmem_ready_i = 1'b1;
        step("mw_rdy", C_NORM, 2'd1, 1'b0, 5, 2);
        idle();
        step("mw_back", C_NORM, 2'd0, 1'b0, 5, 2);

        // Redirect is masked while held, then honoured on the ready cycle
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mj1", C_HOLD, 2'd0, 1'b0, 5, 2);
        mem_jump_i = 1'b1;
        step("mj_held", C_HOLD, 2'd1, 1'b0, 6, 2);
        dmem_ready_i = 1'b1;
        step("mj_rdy", C_RED, 2'd1, 1'b0, 7, 2);
        idle();
        step("mj_back", C_NORM, 2'd0, 1'b0, 7, 3);

        // Timeout after four held cycles
        setin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("to1", C_HOLD, 2'd0, 1'b0, 7, 3);
        step("to2", C_HOLD, 2'd1, 1'b0, 8, 3);
        step("to3", C_HOLD, 2'd1, 1'b0, 9, 3);
        step("to4", C_HOLD, 2'd1, 1'b0, 10, 3);
        step("err1", C_HOLD, 2'd2, 1'b1, 11, 3);
        dmem_ready_i = 1'b1;
        mem_jump_i   = 1'b1;
        step("err_frozen", C_HOLD, 2'd2, 1'b1, 12, 3);
        idle();
        rst_i = 1'b0;
        step("err_rst", C_RST, 2'd0, 1'b0, 0, 0);
        rst_i = 1'b1;
        step("post_rst", C_NORM, 2'd0, 1'b0, 0, 0);

        // Stall counter saturation
        for (int i = 0; i < 20; i++) begin
            setin(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step("sat", C_LU, 2'd0, 1'b0, (i < 15) ? i : 15, 0);
        end
        idle();
        step("sat_end", C_NORM, 2'd0, 1'b0, 15, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
